// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Fetch stage for the single-issue core. Owns the program counter, fetches
// one word at a time from instruction memory using a req/ready wait-state
// handshake, holds it in the instruction register and presents the decode
// fields to the controller. The next PC is chosen on the commit edge from
// PCSrc/Result. A misaligned branch target parks the unit in HALT until reset.
//
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   imem_req/addr            read request and address (address == PC)
//   imem_ready/rdata         read data valid strobe and instruction word
//   stall                    hold current instruction in EXEC
//   PCSrc, Result            next-PC select and branch target
//   instr_valid, commit      IR executing this cycle / retiring this cycle
//   Instr and field slices   Cond, Op, Funct, Rn, RD, Rm, Imm24
//   PC, PCPlus4, PCPlus8     current PC and its +4/+8 offsets
//   halt                     sticky misaligned-target fault
//   retired                  committed-instruction counter (wraps)
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        PCSrc,
  input  logic [31:0] Result,
  output logic        instr_valid,
  output logic        commit,
  output logic [31:0] Instr,
  output logic [3:0]  Cond,
  output logic [1:0]  Op,
  output logic [5:0]  Funct,
  output logic [3:0]  Rn,
  output logic [3:0]  RD,
  output logic [3:0]  Rm,
  output logic [23:0] Imm24,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [31:0] PCPlus8,
  output logic        halt,
  output logic [31:0] retired
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  logic [1:0] state;
  logic       misaligned;

  assign misaligned = PCSrc && (Result[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      PC      <= RESET_PC;
      Instr   <= '0;
      retired <= '0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (imem_ready) begin
            Instr <= imem_rdata;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (!stall) begin
            retired <= retired + 32'd1;
            // A misaligned target still retires the instruction but leaves
            // PC pointing at it, so the faulting address is observable.
            if (misaligned) begin
              state <= HALT;
            end else begin
              PC    <= PCSrc ? Result : PCPlus4;
              state <= FETCH;
            end
          end
        end
        default: state <= HALT;
      endcase
    end
  end

  assign imem_req    = (state == FETCH);
  assign imem_addr   = PC;
  assign instr_valid = (state == EXEC);
  assign commit      = instr_valid && !stall;
  assign halt        = (state == HALT);

  assign PCPlus4 = PC + 32'd4;
  assign PCPlus8 = PC + 32'd8;

  assign Cond  = Instr[31:28];
  assign Op    = Instr[27:26];
  assign Funct = Instr[25:20];
  assign Rn    = Instr[19:16];
  assign RD    = Instr[15:12];
  assign Rm    = Instr[3:0];
  assign Imm24 = Instr[23:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
// Directed, table-driven bench for instr_fetch_unit with RESET_PC = 0x100.
// Each table row gives the inputs held across one rising edge and the outputs
// expected 1 ns after that edge. Reset pulses and field/offset checks are
// done by hand between table segments.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        PCSrc;
  logic [31:0] Result;
  logic        instr_valid;
  logic        commit;
  logic [31:0] Instr;
  logic [3:0]  Cond;
  logic [1:0]  Op;
  logic [5:0]  Funct;
  logic [3:0]  Rn;
  logic [3:0]  RD;
  logic [3:0]  Rm;
  logic [23:0] Imm24;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic [31:0] PCPlus8;
  logic        halt;
  logic [31:0] retired;

  instr_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .stall(stall), .PCSrc(PCSrc), .Result(Result),
    .instr_valid(instr_valid), .commit(commit), .Instr(Instr),
    .Cond(Cond), .Op(Op), .Funct(Funct), .Rn(Rn), .RD(RD), .Rm(Rm),
    .Imm24(Imm24), .PC(PC), .PCPlus4(PCPlus4), .PCPlus8(PCPlus8),
    .halt(halt), .retired(retired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        ready;
    logic [31:0] rdata;
    logic        stl;
    logic        pcsrc;
    logic [31:0] result;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic        e_commit;
    logic [31:0] e_instr;
    logic [31:0] e_retired;
    logic        e_halt;
  } vec_t;

  localparam logic [31:0] A0 = 32'hE3A0_0001;
  localparam logic [31:0] A1 = 32'hE280_0002;
  localparam logic [31:0] W  = 32'hE281_1005;
  localparam logic [31:0] B0 = 32'hEA00_0000;
  localparam logic [31:0] S  = 32'hE1A0_0000;
  localparam logic [31:0] H  = 32'hE12F_FF10;

  vec_t vec [27];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    string tag;
    imem_ready = vec[i].ready;
    imem_rdata = vec[i].rdata;
    stall      = vec[i].stl;
    PCSrc      = vec[i].pcsrc;
    Result     = vec[i].result;
    @(posedge clk);
    #1;
    tag = $sformatf("v%0d", i);
    check({tag, "_req"},     {31'd0, imem_req},    {31'd0, vec[i].e_req});
    check({tag, "_addr"},    imem_addr,            vec[i].e_addr);
    check({tag, "_valid"},   {31'd0, instr_valid}, {31'd0, vec[i].e_valid});
    check({tag, "_commit"},  {31'd0, commit},      {31'd0, vec[i].e_commit});
    check({tag, "_instr"},   Instr,                vec[i].e_instr);
    check({tag, "_retired"}, retired,              vec[i].e_retired);
    check({tag, "_halt"},    {31'd0, halt},        {31'd0, vec[i].e_halt});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},     {31'd0, imem_req},    32'd0);
    check({tag, "_valid"},   {31'd0, instr_valid}, 32'd0);
    check({tag, "_commit"},  {31'd0, commit},      32'd0);
    check({tag, "_halt"},    {31'd0, halt},        32'd0);
    check({tag, "_pc"},      PC,                   32'h0000_0100);
    check({tag, "_addr"},    imem_addr,            32'h0000_0100);
    check({tag, "_instr"},   Instr,                32'd0);
    check({tag, "_retired"}, retired,              32'd0);
  endtask

  initial begin
    //            rdy rdata  stl pcs result          req addr            val cmt instr ret   halt
    vec[0]  = '{1'b1, 32'd0, 1'b0, 1'b0, 32'd0,        1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0};
    vec[1]  = '{1'b1, A0,    1'b0, 1'b0, 32'd0,        1'b0, 32'h0000_0100, 1'b1, 1'b1, A0,    32'd0, 1'b0};
    vec[2]  = '{1'b0, 32'd0, 1'b0, 1'b0, 32'd0,        1'b1, 32'h0000_0104, 1'b0, 1'b0, A0,    32'd1, 1'b0};
    vec[3]  = '{1'b1, A1,    1'b0, 1'b0, 32'd0,        1'b0, 32'h0000_0104, 1'b1, 1'b1, A1,    32'd1, 1'b0};
    vec[4]  = '{1'b0, 32'd0, 1'b0, 1'b0, 32'd0,        1'b1, 32'h0000_0108, 1'b0, 1'b0, A1,    32'd2, 1'b0};
    vec[5]  = '{1'b0, 32'd0, 1'b0, 1'b0, 32'd0,        1'b1, 32'h0000_0108, 1'b0, 1'b0, A1,    32'd2, 1'b0};
    vec[6]  = '{1'b0, 32'd0, 1'b0, 1'b0, 32'd0,        1'b1, 32'h0000_0108, 1'b0, 1'b0, A1,    32'd2, 1'b0};
    vec[7]  = '{1'b0, 32'd0, 1'b0, 1'b0, 32'd0,        1'b1, 32'h0000_0108, 1'b0, 1'b0, A1,    32'd2, 1'b0};
    vec[8]  = '{1'b1, W,     1'b0, 1'b0, 32'd0,        1'b0, 32'h0000_0108, 1'b1, 1'b1, W,     32'd2, 1'b0};
    vec[9]  = '{1'b0, 32'd0, 1'b0, 1'b1, 32'h200,      1'b1, 32'h0000_0200, 1'b0, 1'b0, W,     32'd3, 1'b0};
    vec[10] = '{1'b1, B0,    1'b0, 1'b0, 32'd0,        1'b0, 32'h0000_0200, 1'b1, 1'b1, B0,    32'd3, 1'b0};
    vec[11] = '{1'b0, 32'd0, 1'b0, 1'b1, 32'h400,      1'b1, 32'h0000_0400, 1'b0, 1'b0, B0,    32'd4, 1'b0};
    vec[12] = '{1'b1, S,     1'b1, 1'b0, 32'd0,        1'b0, 32'h0000_0400, 1'b1, 1'b0, S,     32'd4, 1'b0};
    vec[13] = '{1'b1, A0,    1'b1, 1'b1, 32'h800,      1'b0, 32'h0000_0400, 1'b1, 1'b0, S,     32'd4, 1'b0};
    vec[14] = '{1'b1, A0,    1'b1, 1'b0, 32'd0,        1'b0, 32'h0000_0400, 1'b1, 1'b0, S,     32'd4, 1'b0};
    vec[15] = '{1'b1, A0,    1'b1, 1'b0, 32'd0,        1'b0, 32'h0000_0400, 1'b1, 1'b0, S,     32'd4, 1'b0};
    vec[16] = '{1'b1, A0,    1'b1, 1'b0, 32'd0,        1'b0, 32'h0000_0400, 1'b1, 1'b0, S,     32'd4, 1'b0};
    vec[17] = '{1'b0, 32'd0, 1'b0, 1'b0, 32'd0,        1'b1, 32'h0000_0404, 1'b0, 1'b0, S,     32'd5, 1'b0};
    vec[18] = '{1'b1, H,     1'b0, 1'b0, 32'd0,        1'b0, 32'h0000_0404, 1'b1, 1'b1, H,     32'd5, 1'b0};
    vec[19] = '{1'b0, 32'd0, 1'b0, 1'b1, 32'h402,      1'b0, 32'h0000_0404, 1'b0, 1'b0, H,     32'd6, 1'b1};
    vec[20] = '{1'b1, A0,    1'b0, 1'b0, 32'd0,        1'b0, 32'h0000_0404, 1'b0, 1'b0, H,     32'd6, 1'b1};
    vec[21] = '{1'b1, A1,    1'b0, 1'b1, 32'h0,        1'b0, 32'h0000_0404, 1'b0, 1'b0, H,     32'd6, 1'b1};
    vec[22] = '{1'b1, 32'd0, 1'b0, 1'b0, 32'd0,        1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0};
    vec[23] = '{1'b1, A0,    1'b0, 1'b0, 32'd0,        1'b0, 32'h0000_0100, 1'b1, 1'b1, A0,    32'd0, 1'b0};
    vec[24] = '{1'b0, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, A0,   32'd1, 1'b0};
    vec[25] = '{1'b1, A1,    1'b0, 1'b0, 32'd0,        1'b0, 32'hFFFF_FFFC, 1'b1, 1'b1, A1,    32'd1, 1'b0};
    vec[26] = '{1'b0, 32'd0, 1'b0, 1'b0, 32'd0,        1'b1, 32'h0000_0000, 1'b0, 1'b0, A1,    32'd2, 1'b0};

    rst_n      = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = '0;
    stall      = 1'b0;
    PCSrc      = 1'b0;
    Result     = '0;

    #12;
    check_reset_outputs("rst0");
    rst_n = 1'b1;
    #1;
    check("idle_req", {31'd0, imem_req}, 32'd0);

    // Reset release, sequential fetch, wait states, branch, stall, halt.
    for (int i = 0; i <= 21; i++) begin
      run_vec(i);
      if (i == 8) begin
        check("f_cond",  {28'd0, Cond},  32'hE);
        check("f_op",    {30'd0, Op},    32'h0);
        check("f_funct", {26'd0, Funct}, 32'h28);
        check("f_rn",    {28'd0, Rn},    32'h1);
        check("f_rd",    {28'd0, RD},    32'h1);
        check("f_rm",    {28'd0, Rm},    32'h5);
        check("f_imm24", {8'd0, Imm24},  32'h81_1005);
      end
      if (i == 10) begin
        check("br_pc",      PC,      32'h0000_0200);
        check("br_pcplus8", PCPlus8, 32'h0000_0208);
      end
      if (i == 16) begin
        // Dropping stall must raise commit combinationally in the same cycle.
        stall = 1'b0;
        #1;
        check("stall_release_commit", {31'd0, commit}, 32'd1);
      end
      if (i == 21) check("halt_pc", PC, 32'h0000_0404);
    end

    // Reset pulse clears halt asynchronously and restarts at RESET_PC.
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst1");
    #2;
    rst_n = 1'b1;

    for (int i = 22; i <= 26; i++) begin
      run_vec(i);
      if (i == 25) begin
        check("wrap_pcplus4", PCPlus4, 32'h0000_0000);
        check("wrap_pcplus8", PCPlus8, 32'h0000_0004);
      end
    end

    // Reset mid-FETCH with no memory response pending: outputs must change
    // before any further clock edge.
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst2");
    check("rst2_pcplus4", PCPlus4, 32'h0000_0104);
    @(posedge clk);
    #1;
    check("rst2_hold_req", {31'd0, imem_req}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
